// File: rtl/gcd_pkg.sv
// gcd_pkg: shared FSM state encodings for the subtractive and binary GCD engines
package gcd_pkg;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
    typedef enum logic [1:0] {G_IDLE, G_ALIGN, G_REDUCE, G_DONE} gcd_bin_state_t;
endpackage

// File: rtl/gcd_binary_if.sv
// gcd_binary_if: operand/result valid-ready bus of gcd_binary
//   in_valid_i/in_ready_o/a_i/b_i        operand pair handshake (producer -> engine)
//   out_valid_o/out_ready_i/gcd_o/cycles_o result handshake (engine -> consumer)
//   slave modport is the engine side, master modport is the producer/consumer side
interface gcd_binary_if #(
    parameter int XLEN = 32,
    parameter int CNTW = 16
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] gcd_o;
    logic [CNTW-1:0] cycles_o;
    modport slave (
        input  in_valid_i, a_i, b_i, out_ready_i,
        output in_ready_o, out_valid_o, gcd_o, cycles_o
    );
    modport master (
        output in_valid_i, a_i, b_i, out_ready_i,
        input  in_ready_o, out_valid_o, gcd_o, cycles_o
    );
endinterface

// File: rtl/gcd_binary_step.sv
// gcd_binary_step: one combinational ALIGN/REDUCE iteration of Stein's algorithm
//   a_i/b_i/k_i/state_i  current operands, shared power-of-two count, FSM state
//   a_o/b_o/k_o/state_o  values after this iteration; done_o flags A==B in REDUCE
module gcd_binary_step
    import gcd_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int KW   = $clog2(XLEN + 1)
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [KW-1:0]   k_i,
    input  gcd_bin_state_t  state_i,
    output logic [XLEN-1:0] a_o,
    output logic [XLEN-1:0] b_o,
    output logic [KW-1:0]   k_o,
    output logic            done_o,
    output gcd_bin_state_t  state_o
);
    always_comb begin
        a_o     = a_i;
        b_o     = b_i;
        k_o     = k_i;
        done_o  = 1'b0;
        state_o = state_i;
        if (state_i == G_ALIGN) begin
            if (!a_i[0] && !b_i[0]) begin
                a_o = a_i >> 1;
                b_o = b_i >> 1;
                k_o = k_i + 1'b1;
            end else begin
                state_o = G_REDUCE;
            end
        end else if (state_i == G_REDUCE) begin
            // both odd before a subtraction, so the difference is even and the shift is exact
            if (a_i == b_i) begin
                done_o  = 1'b1;
                state_o = G_DONE;
            end else if (!a_i[0]) a_o = a_i >> 1;
            else if (!b_i[0]) b_o = b_i >> 1;
            else if (a_i > b_i) a_o = (a_i - b_i) >> 1;
            else b_o = (b_i - a_i) >> 1;
        end
    end
endmodule

// File: rtl/gcd_binary.sv
// gcd_binary: binary (Stein) GCD engine with valid/ready handshakes, iteration count and abort
//   clk_i     clock, rising edge
//   resetn_i  synchronous active-low reset (wins over abort_i)
//   abort_i   synchronous abort, returns to idle and drops any result
//   bus       gcd_binary_if.slave operand/result handshakes
module gcd_binary
    import gcd_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNTW = 16
) (
    input logic         clk_i,
    input logic         resetn_i,
    input logic         abort_i,
    gcd_binary_if.slave bus
);
    localparam int KW = $clog2(XLEN + 1);
    gcd_bin_state_t  state_q, state_d, step_state;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, r_q, r_d, step_a, step_b;
    logic [KW-1:0]   k_q, k_d, step_k;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            step_done, accept, zero_op, busy;

    gcd_binary_step #(.XLEN(XLEN), .KW(KW)) u_step (
        .a_i(a_q), .b_i(b_q), .k_i(k_q), .state_i(state_q),
        .a_o(step_a), .b_o(step_b), .k_o(step_k), .done_o(step_done), .state_o(step_state)
    );

    // an accept coinciding with abort is discarded
    assign accept  = bus.in_valid_i && state_q == G_IDLE && !abort_i;
    assign zero_op = bus.a_i == '0 || bus.b_i == '0;
    assign busy    = state_q == G_ALIGN || state_q == G_REDUCE;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) state_q <= G_IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) state_d = G_IDLE;
        else if (accept) state_d = zero_op ? G_DONE : G_ALIGN;
        else if (busy) state_d = step_state;
        else if (state_q == G_DONE && bus.out_ready_i) state_d = G_IDLE;
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        k_d   = k_q;
        r_d   = r_q;
        cnt_d = cnt_q;
        if (accept) begin
            a_d   = bus.a_i;
            b_d   = bus.b_i;
            k_d   = '0;
            cnt_d = '0;
            r_d   = zero_op ? (bus.a_i | bus.b_i) : r_q;
        end else if (busy) begin
            a_d   = step_a;
            b_d   = step_b;
            k_d   = step_k;
            cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
            r_d   = step_done ? a_q << k_q : r_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            a_q   <= '0;
            b_q   <= '0;
            k_q   <= '0;
            r_q   <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            k_q   <= k_d;
            r_q   <= r_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        bus.in_ready_o  = state_q == G_IDLE;
        bus.out_valid_o = state_q == G_DONE;
        bus.gcd_o       = r_q;
        bus.cycles_o    = cnt_q;
    end
endmodule
